// File: rtl/sc_lane_shift_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sc_lane_shift_ctrl_if                                           |
// | Purpose  : Bundle of game-event inputs and background-register control     |
// |            outputs exchanged with the lane shift controller.               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface sc_lane_shift_ctrl_if;

    // Game-event requests towards the controller
    logic       start_InLow;
    logic       levelup_InLow;
    logic       lose_InLow;
    logic       pause_InHigh;

    // Control towards the downstream background register and pattern mux
    logic       clear_OutLow;
    logic       load_OutLow;
    logic [1:0] shiftselection_Out;
    logic [1:0] transition_selector_Out;
    logic       gameover_OutHigh;

    // Game logic side: raises events, observes register control
    modport master (
        output start_InLow,
        output levelup_InLow,
        output lose_InLow,
        output pause_InHigh,
        input  clear_OutLow,
        input  load_OutLow,
        input  shiftselection_Out,
        input  transition_selector_Out,
        input  gameover_OutHigh
    );

    // Controller side
    modport slave (
        input  start_InLow,
        input  levelup_InLow,
        input  lose_InLow,
        input  pause_InHigh,
        output clear_OutLow,
        output load_OutLow,
        output shiftselection_Out,
        output transition_selector_Out,
        output gameover_OutHigh
    );

endinterface
`default_nettype wire

// File: rtl/sc_lane_shift_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sc_lane_shift_ctrl                                              |
// | Purpose  : Lane background controller. Clears the background register in   |
// |            IDLE, loads the level pattern, then emits a rotate code every   |
// |            PERIOD_Lx clocks while running. Handles pause, level-up and     |
// |            game-over events. All outputs are registered.                   |
// | Options  : SC_LANE_SHIFT_CTRL_DIRTOGGLE_EN - when defined, the rotate      |
// |            direction flips on every level-up and is restored on restart.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sc_lane_shift_ctrl #(
    parameter int         PRESC_WIDTH = 24,
    parameter int         PERIOD_L1   = 12500000,
    parameter int         PERIOD_L2   = 9375000,
    parameter int         PERIOD_L3   = 6250000,
    parameter int         PERIOD_L4   = 3125000,
    parameter logic [1:0] SHIFT_DIR   = 2'b01
) (
    input  wire logic           SC_RegBACKGTYPE_CLOCK_50,
    input  wire logic           SC_RegBACKGTYPE_RESET_InHigh,
    sc_lane_shift_ctrl_if.slave bus
);

    // Terminal prescaler counts, one per level (count wraps after PERIOD-1)
    localparam logic [PRESC_WIDTH-1:0] TERM_L1 = PRESC_WIDTH'(PERIOD_L1 - 1);
    localparam logic [PRESC_WIDTH-1:0] TERM_L2 = PRESC_WIDTH'(PERIOD_L2 - 1);
    localparam logic [PRESC_WIDTH-1:0] TERM_L3 = PRESC_WIDTH'(PERIOD_L3 - 1);
    localparam logic [PRESC_WIDTH-1:0] TERM_L4 = PRESC_WIDTH'(PERIOD_L4 - 1);
    localparam logic [PRESC_WIDTH-1:0] PRESC_ONE = PRESC_WIDTH'(1);
    localparam logic [1:0]             LEVEL_MAX = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_RUN      = 3'd2,
        ST_PAUSE    = 3'd3,
        ST_LEVELUP  = 3'd4,
        ST_GAMEOVER = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [PRESC_WIDTH-1:0]  presc_q, presc_d;
    logic [1:0]              level_q, level_d;

    // Output registers; their next values are derived from the next state
    logic                    clear_q, clear_d;
    logic                    load_q, load_d;
    logic [1:0]              shift_q, shift_d;
    logic                    gameover_q, gameover_d;

    // Terminal count for the current level and the code driven on a tick
    logic [PRESC_WIDTH-1:0]  term_cnt;
    logic                    at_term;
    logic [1:0]              tick_code;

`ifdef SC_LANE_SHIFT_CTRL_DIRTOGGLE_EN
    logic [1:0]              dir_q, dir_d;

    // Active rotate direction, flipped by level-ups
    always_ff @(posedge SC_RegBACKGTYPE_CLOCK_50 or posedge SC_RegBACKGTYPE_RESET_InHigh) begin
        if (SC_RegBACKGTYPE_RESET_InHigh) begin
            dir_q <= SHIFT_DIR;
        end else begin
            dir_q <= dir_d;
        end
    end

    assign tick_code = dir_q;
`else
    // Fixed direction build: every tick carries the configured code
    assign tick_code = SHIFT_DIR;
`endif

    // Select the wrap point of the prescaler for the current level
    always_comb begin
        term_cnt = TERM_L1;
        case (level_q)
            2'd0:    term_cnt = TERM_L1;
            2'd1:    term_cnt = TERM_L2;
            2'd2:    term_cnt = TERM_L3;
            default: term_cnt = TERM_L4;
        endcase
    end

    assign at_term = (presc_q == term_cnt);

    // State, datapath and output registers; reset forces IDLE outputs at once
    always_ff @(posedge SC_RegBACKGTYPE_CLOCK_50 or posedge SC_RegBACKGTYPE_RESET_InHigh) begin
        if (SC_RegBACKGTYPE_RESET_InHigh) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            level_q    <= 2'd0;
            clear_q    <= 1'b0;
            load_q     <= 1'b1;
            shift_q    <= 2'b00;
            gameover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            level_q    <= level_d;
            clear_q    <= clear_d;
            load_q     <= load_d;
            shift_q    <= shift_d;
            gameover_q <= gameover_d;
        end
    end

    // Next-state, prescaler, level and registered-output decode
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        level_d = level_q;
        shift_d = 2'b00;
`ifdef SC_LANE_SHIFT_CTRL_DIRTOGGLE_EN
        dir_d   = dir_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // Waiting for a game: register held clear, level back to the first
                level_d = 2'd0;
                presc_d = '0;
`ifdef SC_LANE_SHIFT_CTRL_DIRTOGGLE_EN
                dir_d   = SHIFT_DIR;
`endif
                if (!bus.start_InLow) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                // Single load cycle; motion restarts from a fresh prescaler
                presc_d = '0;
                state_d = ST_RUN;
            end

            ST_RUN: begin
                // Events take precedence over counting and swallow a due tick
                if (!bus.lose_InLow) begin
                    state_d = ST_GAMEOVER;
                end else if (!bus.levelup_InLow) begin
                    state_d = ST_LEVELUP;
                end else if (bus.pause_InHigh) begin
                    state_d = ST_PAUSE;
                end else if (at_term) begin
                    presc_d = '0;
                    shift_d = tick_code;
                end else begin
                    presc_d = presc_q + PRESC_ONE;
                end
            end

            ST_PAUSE: begin
                // Count frozen; a collision still ends the game
                if (!bus.lose_InLow) begin
                    state_d = ST_GAMEOVER;
                end else if (!bus.pause_InHigh) begin
                    state_d = ST_RUN;
                end
            end

            ST_LEVELUP: begin
                if (level_q != LEVEL_MAX) begin
                    level_d = level_q + 2'd1;
                end
`ifdef SC_LANE_SHIFT_CTRL_DIRTOGGLE_EN
                // Flip even at the top level so every level-up is visible
                dir_d   = ~dir_q;
`endif
                state_d = ST_LOAD;
            end

            ST_GAMEOVER: begin
                // Lane frozen until a restart, which begins at the first level
                if (!bus.start_InLow) begin
                    level_d = 2'd0;
`ifdef SC_LANE_SHIFT_CTRL_DIRTOGGLE_EN
                    dir_d   = SHIFT_DIR;
`endif
                    state_d = ST_LOAD;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear and load strobes follow the state being entered, so each is
        // asserted for exactly the cycles spent in IDLE and LOAD respectively
        clear_d    = (state_d != ST_IDLE);
        load_d     = (state_d != ST_LOAD);
        gameover_d = (state_d == ST_GAMEOVER);
    end

    assign bus.clear_OutLow            = clear_q;
    assign bus.load_OutLow             = load_q;
    assign bus.shiftselection_Out      = shift_q;
    assign bus.transition_selector_Out = level_q;
    assign bus.gameover_OutHigh        = gameover_q;

endmodule
`default_nettype wire

// File: tb/tb_sc_lane_shift_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sc_lane_shift_ctrl                                           |
// | Purpose  : Self-checking bench for sc_lane_shift_ctrl: directed scenarios  |
// |            followed by randomized events against a reference model.       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_sc_lane_shift_ctrl;

    localparam logic [1:0] C_DIR = 2'b01;
`ifdef SC_LANE_SHIFT_CTRL_DIRTOGGLE_EN
    localparam logic [1:0] C_DIR_FLIP = 2'b10;
`else
    localparam logic [1:0] C_DIR_FLIP = 2'b01;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sc_lane_shift_ctrl_if bus();

    sc_lane_shift_ctrl #(
        .PRESC_WIDTH (8),
        .PERIOD_L1   (4),
        .PERIOD_L2   (3),
        .PERIOD_L3   (2),
        .PERIOD_L4   (2),
        .SHIFT_DIR   (C_DIR)
    ) dut (
        .SC_RegBACKGTYPE_CLOCK_50     (clk),
        .SC_RegBACKGTYPE_RESET_InHigh (rst),
        .bus                          (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase 0 idle, 1 load, 2 run, 3 pause, 4 levelup, 5 gameover
    int         m_phase;
    int         m_level;
    int         m_cnt;
    logic [1:0] m_dir;
    logic [1:0] m_shift;

    function automatic int period(input int lvl);
        case (lvl)
            0:       return 4;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_level = 0;
        m_cnt   = 0;
        m_dir   = C_DIR;
        m_shift = 2'b00;
    endtask

    // One clock edge of game behaviour, using the inputs currently driven
    task automatic model_step();
        if (rst) begin
            model_reset();
            return;
        end
        m_shift = 2'b00;
        if (m_phase == 0) begin
            m_level = 0;
            m_dir   = C_DIR;
            if (!bus.start_InLow) m_phase = 1;
        end else if (m_phase == 1) begin
            m_cnt   = 0;
            m_phase = 2;
        end else if (m_phase == 2) begin
            if (!bus.lose_InLow)         m_phase = 5;
            else if (!bus.levelup_InLow) m_phase = 4;
            else if (bus.pause_InHigh)   m_phase = 3;
            else begin
                m_cnt = m_cnt + 1;
                if (m_cnt == period(m_level)) begin
                    m_cnt   = 0;
                    m_shift = m_dir;
                end
            end
        end else if (m_phase == 3) begin
            if (!bus.lose_InLow)       m_phase = 5;
            else if (!bus.pause_InHigh) m_phase = 2;
        end else if (m_phase == 4) begin
            m_level = (m_level >= 3) ? 3 : m_level + 1;
`ifdef SC_LANE_SHIFT_CTRL_DIRTOGGLE_EN
            m_dir   = (m_dir == 2'b01) ? 2'b10 : 2'b01;
`endif
            m_phase = 1;
        end else begin
            if (!bus.start_InLow) begin
                m_level = 0;
                m_dir   = C_DIR;
                m_phase = 1;
            end
        end
    endtask

    task automatic check_all(input string ctx);
        int act;
        chk({ctx, "/clear"},    32'(bus.clear_OutLow),            32'(m_phase != 0));
        chk({ctx, "/load"},     32'(bus.load_OutLow),             32'(m_phase != 1));
        chk({ctx, "/gameover"}, 32'(bus.gameover_OutHigh),        32'(m_phase == 5));
        chk({ctx, "/level"},    32'(bus.transition_selector_Out), 32'(m_level));
        chk({ctx, "/shift"},    32'(bus.shiftselection_Out),      32'(m_shift));
        act = 32'(!bus.clear_OutLow) + 32'(!bus.load_OutLow) + 32'(bus.shiftselection_Out != 2'b00);
        chk({ctx, "/exclusive"}, 32'(act <= 1), 32'd1);
    endtask

    task automatic step(input string ctx);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(ctx);
    endtask

    task automatic drive(input logic s, input logic l, input logic lo, input logic p);
        bus.start_InLow   = s;
        bus.levelup_InLow = l;
        bus.lose_InLow    = lo;
        bus.pause_InHigh  = p;
    endtask

    // Steps until a shift pulse is seen; n is the number of steps taken
    task automatic wait_pulse(input string ctx, input int budget, output int n);
        bit found;
        found = 1'b0;
        n = 0;
        for (int i = 0; i < budget; i++) begin
            step(ctx);
            n++;
            if (bus.shiftselection_Out != 2'b00) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) chk({ctx, "/pulse_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        logic p_hold;

        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        model_reset();
        @(negedge clk);
        check_all("reset");
        rst = 1'b0;
        step("idle");
        step("idle");

        // Start: one load cycle at level 0, then a tick every 4 clocks
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        step("start");
        chk("start_load", 32'(bus.load_OutLow), 32'd0);
        chk("start_level", 32'(bus.transition_selector_Out), 32'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        wait_pulse("first_tick", 12, n);
        chk("first_tick_delay", 32'(n), 32'd5);
        for (int k = 0; k < 2; k++) begin
            wait_pulse("tick_gap", 12, n);
            chk("tick_gap_l0", 32'(n), 32'd4);
        end

        // Pause for 10 cycles with the count at 2
        for (int i = 0; i < 8 && !(m_phase == 2 && m_cnt == 2); i++) step("to_cnt2");
        chk("at_cnt2", 32'(m_cnt), 32'd2);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step("paused");
            chk("pause_quiet", 32'(bus.shiftselection_Out), 32'd0);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        step("release");
        wait_pulse("resume", 10, n);
        chk("resume_delay", 32'(n), 32'd2);

        // Four level-ups: level saturates at 3, tick spacing follows the level
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0);
            step("levelup");
            drive(1'b1, 1'b1, 1'b1, 1'b0);
            step("lvl_load");
            chk("lvl_load_strobe", 32'(bus.load_OutLow), 32'd0);
            chk("lvl_index", 32'(bus.transition_selector_Out), 32'((k < 3) ? k + 1 : 3));
            wait_pulse("lvl_tick", 12, n);
            wait_pulse("lvl_tick", 12, n);
            chk("lvl_gap", 32'(n), 32'(period((k < 3) ? k + 1 : 3)));
        end

        // Lose and level-up together on a due tick: game over, no pulse
        for (int i = 0; i < 8 && !(m_phase == 2 && m_cnt == period(m_level) - 1); i++) step("to_term");
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        step("lose_on_tick");
        chk("lose_gameover", 32'(bus.gameover_OutHigh), 32'd1);
        chk("lose_no_pulse", 32'(bus.shiftselection_Out), 32'd0);
        chk("lose_level_kept", 32'(bus.transition_selector_Out), 32'd3);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (3) step("gameover_hold");
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        step("restart");
        chk("restart_load", 32'(bus.load_OutLow), 32'd0);
        chk("restart_level", 32'(bus.transition_selector_Out), 32'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (4) step("run");

        // Asynchronous reset in the middle of a cycle
        @(posedge clk);
        model_step();
        #2 rst = 1'b1;
        #1;
        chk("async_clear", 32'(bus.clear_OutLow), 32'd0);
        chk("async_load", 32'(bus.load_OutLow), 32'd1);
        chk("async_shift", 32'(bus.shiftselection_Out), 32'd0);
        chk("async_level", 32'(bus.transition_selector_Out), 32'd0);
        chk("async_gameover", 32'(bus.gameover_OutHigh), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step("post_reset");

        // Direction across two level-ups
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        step("dir_start");
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        wait_pulse("dir_t0", 12, n);
        chk("dir_code0", 32'(bus.shiftselection_Out), 32'(C_DIR));
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        step("dir_lu1");
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        wait_pulse("dir_t1", 12, n);
        chk("dir_code1", 32'(bus.shiftselection_Out), 32'(C_DIR_FLIP));
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        step("dir_lu2");
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        wait_pulse("dir_t2", 12, n);
        chk("dir_code2", 32'(bus.shiftselection_Out), 32'(C_DIR));

        // Randomized events with occasional resets
        p_hold = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) p_hold = ~p_hold;
            drive($urandom_range(0, 7) != 0,
                  $urandom_range(0, 11) != 0,
                  $urandom_range(0, 39) != 0,
                  p_hold);
            rst = ($urandom_range(0, 299) == 0);
            step("random");
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
